// File: rtl/us_msg_arbiter_if.sv
// Upstream FIFO read side plus output message stream of the KU receive-path arbiter.
// master = the arbiter, slave = FIFOs / downstream sink.
interface us_msg_arbiter_if #(
   parameter int US_CHANNEL = 6,
   parameter int DATA_W     = 128
);
   logic [US_CHANNEL*DATA_W-1:0] rd_din_i;
   logic [US_CHANNEL-1:0]        rd_empty_i;
   logic [US_CHANNEL-1:0]        rd_en_o;
   logic [DATA_W-1:0]            m_tdata_o;
   logic                         m_tvalid_o;
   logic                         m_tready_i;
   logic                         m_tlast_o;
   logic [2:0]                   m_tchan_o;
   logic                         err_hdr_o;
   logic [2:0]                   err_chan_o;
   logic                         busy_o;

   modport master (
      input  rd_din_i, rd_empty_i, m_tready_i,
      output rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tchan_o,
             err_hdr_o, err_chan_o, busy_o
   );

   modport slave (
      output rd_din_i, rd_empty_i, m_tready_i,
      input  rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, m_tchan_o,
             err_hdr_o, err_chan_o, busy_o
   );
endinterface

// File: rtl/us_msg_arbiter.sv
// Round-robin arbiter forwarding whole framed messages from FWFT FIFOs onto one stream.
// A channel holds the grant until its message's last beat; bad headers are dropped and flagged.
module us_msg_arbiter #(
   parameter int          US_CHANNEL = 6,
   parameter int          DATA_W     = 128,
   parameter logic [31:0] HDR_SYNC   = 32'hFDF7EB90
) (
   input  logic              sys_clk_i,
   input  logic              rst_n_i,
   us_msg_arbiter_if.master  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_XFER} state_t;

   state_t            r_state;
   logic [2:0]        r_gnt;
   logic [2:0]        r_rr_ptr;
   logic [18:0]       r_cnt;
   logic [DATA_W-1:0] r_tdata;
   logic              r_tvalid;
   logic              r_tlast;
   logic [2:0]        r_tchan;
   logic              r_err_hdr;
   logic [2:0]        r_err_chan;
   logic              r_busy;

   logic [US_CHANNEL-1:0][DATA_W-1:0] w_lane_data;
   logic [US_CHANNEL-1:0]             w_lane_sel;
   logic [US_CHANNEL-1:0]             w_lane_ne;
   logic [DATA_W-1:0]                 w_beat;
   logic                              w_gnt_ne;
   logic                              w_can;
   logic                              w_pop;
   logic                              w_emit;
   logic                              w_sync_ok;
   logic [18:0]                       w_len_m1;
   logic [2:0]                        w_next_ptr;
   logic                              w_found;
   logic [2:0]                        w_pick;

   // Per-channel select: each lane contributes its data only when granted, so the
   // granted beat is a plain OR across lanes.
   for (genvar c = 0; c < US_CHANNEL; c++) begin : g_lane
      assign w_lane_sel[c]  = (r_gnt == 3'(c));
      assign w_lane_data[c] = w_lane_sel[c] ? bus.rd_din_i[DATA_W*c +: DATA_W] : '0;
      assign w_lane_ne[c]   = w_lane_sel[c] & ~bus.rd_empty_i[c];
   end

   always_comb begin
      w_beat = '0;
      for (int c = 0; c < US_CHANNEL; c++) w_beat = w_beat | w_lane_data[c];
   end

   assign w_gnt_ne  = |w_lane_ne;
   assign w_can     = ~r_tvalid | bus.m_tready_i;
   assign w_pop     = (r_state != ST_IDLE) & w_gnt_ne & w_can;
   assign w_sync_ok = (w_beat[47:16] == HDR_SYNC);
   assign w_emit    = w_pop & ((r_state == ST_XFER) | w_sync_ok);
   // (frame_len+1)*4 - 1 fits 19 bits for every 16-bit frame_len.
   assign w_len_m1  = (({3'b000, w_beat[15:0]} + 19'd1) << 2) - 19'd1;
   assign w_next_ptr = (r_gnt == 3'(US_CHANNEL - 1)) ? 3'd0 : r_gnt + 3'd1;

   // Cyclic search starting at r_rr_ptr; the first non-empty channel wins.
   always_comb begin
      logic [3:0] sum;
      w_found = 1'b0;
      w_pick  = '0;
      sum     = '0;
      for (int k = 0; k < US_CHANNEL; k++) begin
         sum = {1'b0, r_rr_ptr} + 4'(k);
         if (sum >= 4'(US_CHANNEL)) sum = sum - 4'(US_CHANNEL);
         for (int c = 0; c < US_CHANNEL; c++) begin
            if (!w_found && sum[2:0] == 3'(c) && !bus.rd_empty_i[c]) begin
               w_found = 1'b1;
               w_pick  = 3'(c);
            end
         end
      end
   end

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_rr_ptr   <= '0;
         r_cnt      <= '0;
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
         r_tchan    <= '0;
         r_err_hdr  <= 1'b0;
         r_err_chan <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_err_hdr <= 1'b0;
         if (w_emit) begin
            r_tdata  <= w_beat;
            r_tvalid <= 1'b1;
            r_tlast  <= (r_state == ST_XFER) && (r_cnt == 19'd1);
            r_tchan  <= r_gnt;
         end else if (bus.m_tready_i) begin
            r_tvalid <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_gnt   <= w_pick;
                  r_state <= ST_HDR;
                  r_busy  <= 1'b1;
               end
            end
            ST_HDR: begin
               if (w_pop) begin
                  if (w_sync_ok) begin
                     r_cnt   <= w_len_m1;
                     r_state <= ST_XFER;
                  end else begin
                     r_err_hdr  <= 1'b1;
                     r_err_chan <= r_gnt;
                     r_rr_ptr   <= w_next_ptr;
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                  end
               end
            end
            ST_XFER: begin
               // An empty granted FIFO simply stalls here; the grant is never yielded mid-message.
               if (w_pop) begin
                  r_cnt <= r_cnt - 19'd1;
                  if (r_cnt == 19'd1) begin
                     r_rr_ptr <= w_next_ptr;
                     r_state  <= ST_IDLE;
                     r_busy   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_en_o    = w_lane_sel & {US_CHANNEL{w_pop}};
   assign bus.m_tdata_o  = r_tdata;
   assign bus.m_tvalid_o = r_tvalid;
   assign bus.m_tlast_o  = r_tlast;
   assign bus.m_tchan_o  = r_tchan;
   assign bus.err_hdr_o  = r_err_hdr;
   assign bus.err_chan_o = r_err_chan;
   assign bus.busy_o     = r_busy;

endmodule

// File: doc/us_msg_arbiter.md
# us_msg_arbiter

Upstream message arbiter for the KU receive path. Reads framed messages from `US_CHANNEL` first-word-fall-through FIFOs and forwards them, one whole message at a time, onto a single 128-bit output stream. Channels are served round-robin and a channel keeps the grant until its message completes. Beats that do not start with a valid header are discarded and flagged.

## Interface
Parameters:
- `US_CHANNEL`, 6: number of upstream FIFO channels, 1..8.
- `DATA_W`, 128: beat width in bits.
- `HDR_SYNC`, 32'hFDF7EB90: sync word expected in header beat bits [47:16].

Ports:
- `sys_clk_i`  in  1: single clock; all logic runs on its rising edge.
- `rst_n_i`  in  1: asynchronous, active-low reset.
- `rd_din_i`  in  US_CHANNEL*DATA_W: FIFO data. Channel c occupies [DATA_W*c +: DATA_W] and is valid whenever `rd_empty_i[c]`=0.
- `rd_empty_i`  in  US_CHANNEL: FIFO empty flags.
- `rd_en_o`  out  US_CHANNEL: FIFO pop, one cycle per beat consumed.
- `m_tdata_o`  out  DATA_W: output beat.
- `m_tvalid_o`  out  1: output beat valid.
- `m_tready_i`  in  1: downstream accept.
- `m_tlast_o`  out  1: last beat of the message.
- `m_tchan_o`  out  3: source channel of the current beat.
- `err_hdr_o`  out  1: one-cycle pulse when a non-header beat is dropped.
- `err_chan_o`  out  3: channel of the last drop; holds its value until the next drop.
- `busy_o`  out  1: high when not in the IDLE state.

## Operation
- Header beat format: [47:16] = sync word, [15:0] = `frame_len`. Message length is (frame_len+1)*4 beats, header included, so the minimum is 4 and the maximum is 262144.
- The beat counter is 19 bits. Its load value is computed as ({3'b0,frame_len}+1)<<2 minus 1, with no overflow.
- FSM states: IDLE, HDR, XFER.
- IDLE:
  - Round-robin search begins at `rr_ptr`; the first channel with empty=0 wins.
  - The grant is registered into `gnt`. Next state is HDR.
  - If no channel is non-empty, stay in IDLE.
- HDR: evaluated only when the output stage can accept a beat (`m_tvalid_o`=0 or `m_tready_i`=1).
  - Sync word matches: pop the beat and emit it with tlast=0. Load counter = length−1. Go to XFER.
  - Sync word mismatches: pop and discard the beat. Pulse `err_hdr_o` and set `err_chan_o`=gnt. Set rr_ptr=gnt+1, wrapping to 0 at US_CHANNEL. Go to IDLE.
- XFER: a beat is popped and emitted when `rd_empty_i[gnt]`=0 and the output stage can accept. Each pop decrements the counter.
  - The pop made with counter=1 carries tlast=1. Set rr_ptr=gnt+1 (wrapped) and go to IDLE.
- Empty on the granted channel mid-message: stall and keep the grant. There is no timeout and other channels are never interleaved.
- Pop rule: `rd_en_o[c]` = (state pops) & (c==gnt) & ~rd_empty_i[c] & (~m_tvalid_o | m_tready_i). At most one bit of `rd_en_o` is high in any cycle.
- Output register: loaded on a pop, together with tdata, tlast and tchan.
  - `m_tvalid_o` clears when tready=1 and no new pop occurs.
  - Registered data must not change while tvalid=1 and tready=0.

## Timing
- Reset values: every output is 0, state=IDLE, rr_ptr=0, gnt=0, counter=0.
- Reset mid-message:
  - Outputs clear immediately on assertion, and the partial message is abandoned.
  - After release, the next beat in any FIFO is treated as a header candidate.
- Latency from FIFO non-empty to first output:
  - 1 cycle in IDLE (grant), then the header pop in HDR.
  - `m_tvalid_o` rises the cycle after the pop, i.e. 2 clocks after the IDLE cycle that saw empty=0.
- With no backpressure and no gaps, one beat is popped per cycle. A message of N beats occupies N+1 cycles of arbiter time, including the IDLE grant cycle.
- Simultaneous requests: the lowest channel index at or after rr_ptr (cyclic) wins.
- Backpressure: with tready=0, tvalid=1 and no pop, the state and counter freeze.
- `err_hdr_o` is high for exactly one cycle, the cycle after the discard pop.

## Test plan
- Channel 0 presents header {80'h0, 32'hFDF7EB90, 16'h0000} followed by 3 data beats of 128'h0102030405060708090a0b0c0e0f, tready=1:
  - 4 output beats with m_tchan_o=0 and the header first.
  - m_tlast_o=1 on beat 4 only; busy_o falls after it.
- Channels 0 and 1 each present a frame_len=0 message in the same cycle:
  - All 4 channel-0 beats go out first, then all 4 channel-1 beats.
  - No interleaving and no dropped beats.
- Channel 2 presents frame_len=1 (8 beats) while m_tready_i toggles 1,0,0,1,… continuously:
  - Exactly 8 beats are accepted, in order, with data stable while stalled.
  - rd_en_o is never high while output is blocked.
- Channel 3 presents a first beat of 48'h123456780000:
  - The beat is dropped and err_hdr_o pulses once with err_chan_o=3.
  - A valid header that follows is then forwarded normally.
- Channel 1's empty flag rises for 5 cycles mid-message while channel 4 is non-empty:
  - The grant stays on channel 1; channel 4 starts only after channel 1's tlast.
- rst_n_i is pulled low after beat 2 of a 4-beat message, then released and the FIFO supplies a fresh valid message:
  - Outputs go to 0 immediately.
  - After release, the fresh message is forwarded completely.
